// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider (div_seq).
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   // Explicit encodings so the debug state bus stays stable across revisions.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring step: shift in the next dividend bit, then add or
// subtract the divisor depending on the sign of the previous partial remainder.
module div_nr_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             prev_neg,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic           unused_rem_msb;

   // The MSB is shifted out; its sign information arrives through prev_neg.
   assign unused_rem_msb = rem_in[WIDTH];

   always_comb begin
      shifted = {rem_in[WIDTH-1:0], bit_in};
      if (prev_neg) begin
         rem_out = shifted + {1'b0, divisor};
      end else begin
         rem_out = shifted - {1'b0, divisor};
      end
      q_bit = ~rem_out[WIDTH];
   end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 non-restoring divider, fixed WIDTH+1 cycle latency.
// Signed operation is built only when DIV_SEQ_SIGNED_EN is defined.
//
// Handshake: start is sampled only while idle (including the done cycle);
// busy is high from the accepting edge until the result edge; done pulses
// for one cycle with q/r/div_zero, which then hold until the next result.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_e       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH:0]   rem_q,      rem_d;
   logic [WIDTH-1:0] qsr_q,      qsr_d;
   logic [WIDTH-1:0] dvs_q,      dvs_d;
   logic [WIDTH-1:0] dvd_raw_q,  dvd_raw_d;
   logic [WIDTH-1:0] q_q,        q_d;
   logic [WIDTH-1:0] r_q,        r_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH:0]   step_rem;
   logic             step_q;

`ifdef DIV_SEQ_SIGNED_EN
   logic q_neg_q, q_neg_d;
   logic r_neg_q, r_neg_d;
   logic dvd_neg;
   logic dvs_neg;

   always_comb begin
      dvd_neg = sign_mode & dividend[WIDTH-1];
      dvs_neg = sign_mode & divisor[WIDTH-1];
      dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
      dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
      q_res   = q_neg_q ? (~q_mag + 1'b1) : q_mag;
      r_res   = r_neg_q ? (~r_mag + 1'b1) : r_mag;
   end
`else
   logic unused_sign_mode;

   assign unused_sign_mode = sign_mode;

   always_comb begin
      dvd_mag = dividend;
      dvs_mag = divisor;
      q_res   = q_mag;
      r_res   = r_mag;
   end
`endif

   div_nr_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in   (rem_q),
      .bit_in   (qsr_q[WIDTH-1]),
      .divisor  (dvs_q),
      .prev_neg (rem_q[WIDTH]),
      .rem_out  (step_rem),
      .q_bit    (step_q)
   );

   // qsr starts as the dividend magnitude and fills with quotient bits from
   // the bottom, so after WIDTH steps it holds the unsigned quotient.
   assign q_mag = qsr_q;
   assign r_mag = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      qsr_d      = qsr_q;
      dvs_d      = dvs_q;
      dvd_raw_d  = dvd_raw_q;
      q_d        = q_q;
      r_d        = r_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
`ifdef DIV_SEQ_SIGNED_EN
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CALC;
               cnt_d     = '0;
               rem_d     = '0;
               qsr_d     = dvd_mag;
               dvs_d     = dvs_mag;
               dvd_raw_d = dividend;
               busy_d    = 1'b1;
`ifdef DIV_SEQ_SIGNED_EN
               q_neg_d   = dvd_neg ^ dvs_neg;
               r_neg_d   = dvd_neg;
`endif
            end
         end
         CALC: begin
            rem_d = step_rem;
            qsr_d = {qsr_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // A zero divisor runs the full latency; the result is overridden here.
            if (dvs_q == '0) begin
               q_d        = '1;
               r_d        = dvd_raw_q;
               div_zero_d = 1'b1;
            end else begin
               q_d        = q_res;
               r_d        = r_res;
               div_zero_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         qsr_q      <= '0;
         dvs_q      <= '0;
         dvd_raw_q  <= '0;
         q_q        <= '0;
         r_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         qsr_q      <= qsr_d;
         dvs_q      <= dvs_d;
         dvd_raw_q  <= dvd_raw_d;
         q_q        <= q_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
`ifdef DIV_SEQ_SIGNED_EN
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
`endif
      end
   end

   assign q         = q_q;
   assign r         = r_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH=32): latency, results, divide-by-zero,
// start-while-busy, back-to-back start and mid-operation reset.
module tb_div_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic        sign_mode;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [1:0]  dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;
   int lat;
   int dones;

   div_seq #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .sign_mode (sign_mode),
      .dividend  (dividend),
      .divisor   (divisor),
      .q         (q),
      .r         (r),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .dbg_state (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge; start is sampled on the next edge (E0).
   task automatic run_op(input logic [31:0] dd, input logic [31:0] dv, input logic sm,
                         output int n);
      dividend  = dd;
      divisor   = dv;
      sign_mode = sm;
      start     = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_after_e0", {63'd0, busy}, 64'd1);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      sign_mode = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_q",        {32'd0, q}, 64'd0);
      check("rst_r",        {32'd0, r}, 64'd0);
      check("rst_busy",     {63'd0, busy}, 64'd0);
      check("rst_done",     {63'd0, done}, 64'd0);
      check("rst_div_zero", {63'd0, div_zero}, 64'd0);
      check("rst_state",    {62'd0, dbg_state}, 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // 100 / 7 unsigned
      run_op(32'd100, 32'd7, 1'b0, lat);
      check("u_latency", 64'(lat), 64'd33);
      check("u_q",       {32'd0, q}, 64'd14);
      check("u_r",       {32'd0, r}, 64'd2);
      check("u_dz",      {63'd0, div_zero}, 64'd0);
      check("u_busy",    {63'd0, busy}, 64'd0);
      @(posedge clock); #1;
      check("u_done_pulse", {63'd0, done}, 64'd0);
      check("u_q_hold",     {32'd0, q}, 64'd14);
      check("u_state_idle", {62'd0, dbg_state}, 64'd0);

      // -7 / 2 with sign_mode=1
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
      check("s_latency", 64'(lat), 64'd33);
`ifdef DIV_SEQ_SIGNED_EN
      check("s_q", {32'd0, q}, 64'h0000_0000_FFFF_FFFD);
      check("s_r", {32'd0, r}, 64'h0000_0000_FFFF_FFFF);
`else
      check("s_q", {32'd0, q}, 64'h0000_0000_7FFF_FFFC);
      check("s_r", {32'd0, r}, 64'd1);
`endif

      // Divide by zero, started in the done cycle of the previous op
      run_op(32'h1234_5678, 32'd0, 1'b0, lat);
      check("dz_latency", 64'(lat), 64'd33);
      check("dz_q",       {32'd0, q}, 64'h0000_0000_FFFF_FFFF);
      check("dz_r",       {32'd0, r}, 64'h0000_0000_1234_5678);
      check("dz_flag",    {63'd0, div_zero}, 64'd1);

      // Most-negative / -1
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
      check("ovf_latency", 64'(lat), 64'd33);
`ifdef DIV_SEQ_SIGNED_EN
      check("ovf_q", {32'd0, q}, 64'h0000_0000_8000_0000);
      check("ovf_r", {32'd0, r}, 64'd0);
`else
      check("ovf_q", {32'd0, q}, 64'd0);
      check("ovf_r", {32'd0, r}, 64'h0000_0000_8000_0000);
`endif
      check("ovf_dz", {63'd0, div_zero}, 64'd0);

      // Divisor larger than dividend, and all-ones / 1
      run_op(32'd5, 32'd9, 1'b0, lat);
      check("small_q", {32'd0, q}, 64'd0);
      check("small_r", {32'd0, r}, 64'd5);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
      check("max_q", {32'd0, q}, 64'h0000_0000_FFFF_FFFF);
      check("max_r", {32'd0, r}, 64'd0);
      @(posedge clock); #1;

      // Start while busy: second request at cycle 10 must be ignored
      dividend  = 32'd1000;
      divisor   = 32'd10;
      sign_mode = 1'b0;
      start     = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         if (lat == 10) begin
            dividend = 32'd5;
            divisor  = 32'd1;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         lat++;
      end
      start = 1'b0;
      check("bz_latency", 64'(lat), 64'd33);
      check("bz_q",       {32'd0, q}, 64'd100);
      check("bz_r",       {32'd0, r}, 64'd0);
      check("bz_busy",    {63'd0, busy}, 64'd0);

      // Start held during the done cycle: accepted back-to-back
      dividend = 32'd77;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("b2b_busy",  {63'd0, busy}, 64'd1);
      check("b2b_done",  {63'd0, done}, 64'd0);
      check("b2b_state", {62'd0, dbg_state}, 64'd1);
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      check("b2b_latency", 64'(lat), 64'd33);
      check("b2b_q",       {32'd0, q}, 64'd15);
      check("b2b_r",       {32'd0, r}, 64'd2);
      @(posedge clock); #1;

      // Reset at cycle 15 of an operation
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("mr_busy",  {63'd0, busy}, 64'd0);
      check("mr_q",     {32'd0, q}, 64'd0);
      check("mr_r",     {32'd0, r}, 64'd0);
      check("mr_done",  {63'd0, done}, 64'd0);
      check("mr_state", {62'd0, dbg_state}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      check("mr_no_done", 64'(dones), 64'd0);
      check("mr_q_after", {32'd0, q}, 64'd0);

      // First operation after reset release
      run_op(32'd200, 32'd9, 1'b0, lat);
      check("pr_latency", 64'(lat), 64'd33);
      check("pr_q",       {32'd0, q}, 64'd22);
      check("pr_r",       {32'd0, r}, 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clock  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 The block SHALL have port sign_mode  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 The block SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 The block SHALL have port q  output  WIDTH  quotient, registered.
REQ-009 The block SHALL have port r  output  WIDTH  remainder, registered.
REQ-010 The block SHALL have port busy  output  1  high while the operation is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when q/r/div_zero become valid.
REQ-012 The block SHALL have port div_zero  output  1  divisor was zero for the completed operation.

Function
REQ-013 The block SHALL implement a non-restoring radix-2 iteration (one quotient bit per cycle), with the partial remainder kept WIDTH+1 bits wide.
REQ-014 The block SHALL use the state machine IDLE -> CALC -> FIX -> IDLE.
- IDLE->CALC on start.
- CALC->FIX after exactly WIDTH iteration cycles.
- FIX->IDLE unconditionally.
REQ-015 The edge that samples start in IDLE (E0) SHALL latch the operands, operand magnitudes and sign_mode, set busy=1, and clear the iteration counter.
REQ-016 Timing relative to E0:
- Iteration SHALL occur on edges E1..E_WIDTH.
- Edge E_WIDTH+1 (FIX) SHALL apply the remainder correction (add divisor if negative), apply sign fix-up, write q/r/div_zero, assert done, and deassert busy.
- Fixed latency SHALL be WIDTH+1 cycles for all operands.
REQ-017 done SHALL be high for exactly one cycle; q/r/div_zero SHALL hold their values until the FIX of the next operation.
REQ-018 start while busy SHALL be ignored; the operation in flight SHALL NOT restart and operands SHALL NOT be re-latched.
REQ-019 start asserted in the cycle done is high SHALL be accepted (back-to-back operations, one idle-free cycle).
REQ-020 Unsigned results SHALL satisfy dividend = q*divisor + r, with 0 <= r < divisor.
REQ-021 Signed results SHALL truncate toward zero; r SHALL take the sign of the dividend and satisfy |r| < |divisor|.
REQ-022 Divisor zero SHALL give q = all ones, r = dividend, div_zero=1, with the normal latency.
REQ-023 Signed most-negative / -1 SHALL give q = most-negative, r = 0, div_zero=0.

Reset
REQ-024 Asserting reset at any time, including mid-operation, SHALL force state IDLE and q=0, r=0, busy=0, done=0, div_zero=0, and clear the counter; the operation in flight SHALL be discarded.
REQ-025 The first start after reset release SHALL behave as in REQ-015.

Configuration
REQ-026 With macro DIV_SEQ_SIGNED_EN defined, sign_mode and the signed behaviour of REQ-021/REQ-023 SHALL be implemented.
REQ-027 Without DIV_SEQ_SIGNED_EN, the sign_mode port SHALL remain present but be ignored, all operations SHALL be unsigned, and no sign fix-up logic SHALL be synthesised; latency SHALL be unchanged.

Structure
REQ-028 A shared package div_pkg SHALL hold the state enum (IDLE, CALC, FIX) and the constant for the default width.
REQ-029 The add/subtract step SHALL be the sub-module div_nr_step (combinational: partial remainder, next dividend bit, divisor, previous sign -> new partial remainder, quotient bit).

Verification (WIDTH=32)
REQ-030 Unsigned test: dividend=100, divisor=7, sign_mode=0 -> done 33 cycles after the start edge, q=14, r=2, div_zero=0.
REQ-031 Signed test: dividend=0xFFFFFFF9 (-7), divisor=2, sign_mode=1 -> q=0xFFFFFFFD, r=0xFFFFFFFF; without the macro -> q=0x7FFFFFFC, r=1.
REQ-032 Divide by zero: dividend=0x12345678, divisor=0 -> q=0xFFFFFFFF, r=0x12345678, div_zero=1, done at the normal latency.
REQ-033 Signed overflow: dividend=0x80000000, divisor=0xFFFFFFFF, sign_mode=1 -> q=0x80000000, r=0, div_zero=0.
REQ-034 Start while busy: second start at cycle 10 with different operands -> first result unchanged and busy not extended; start held during the done cycle -> next result 33 cycles later.
REQ-035 Reset mid-operation: reset at cycle 15 -> busy=0, q=0, r=0 immediately, and no done pulse follows.
